// File: rtl/pipelined_addsub.sv
// Purpose: WIDTH-bit adder/subtractor split into STAGES chunks with a registered carry between chunks; optional signed saturation under ADDSUB_SAT_EN.
// Latency: STAGES cycles from the operand cycle to out_valid, one operation per cycle.
// Backpressure: the whole pipeline holds while out_valid && !out_ready; in_ready drops in the same cycle.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int C    = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Reject configurations that would silently drop operand bits.
    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_cfg_err
        $error("pipelined_addsub: STAGES must be in 1..WIDTH and divide WIDTH exactly");
    end

    // Stage registers. a/b' carry the not-yet-added high chunks forward (skew),
    // s holds the already-computed low sum chunks (deskew).
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  bp_q [STAGES];
    logic [WIDTH-1:0]  s_q  [STAGES];

    // Inputs seen by each stage and what each stage will register.
    logic [STAGES-1:0] st_v;
    logic [STAGES-1:0] st_c;
    logic [STAGES-1:0] nx_c;
    logic [WIDTH-1:0]  st_a [STAGES];
    logic [WIDTH-1:0]  st_b [STAGES];
    logic [WIDTH-1:0]  st_s [STAGES];
    logic [WIDTH-1:0]  nx_s [STAGES];
    logic [C:0]        csum [STAGES];

    logic              adv;
    logic [WIDTH-1:0]  raw_y;
    logic [WIDTH-1:0]  fin_y;
    logic              fin_cout;
    logic              fin_ovf;
    logic              carry_into_msb;

    logic [WIDTH-1:0]  y_q;
    logic              cout_q;
    logic              ovf_q;
    logic              zero_q;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[LAST];
    assign y         = y_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    // Route each stage's inputs and add its own C-bit chunk with the incoming carry.
    always_comb begin
        st_v = '0;
        st_c = '0;
        nx_c = '0;
        for (int k = 0; k < STAGES; k++) begin
            st_a[k] = '0;
            st_b[k] = '0;
            st_s[k] = '0;
            nx_s[k] = '0;
            csum[k] = '0;
        end
        // Subtraction is a + ~b + 1; the borrow-in inverts that implicit +1.
        st_v[0] = in_valid;
        st_a[0] = a;
        st_b[0] = sub ? ~b : b;
        st_s[0] = '0;
        st_c[0] = sub ? ~cin : cin;
        for (int k = 1; k < STAGES; k++) begin
            st_v[k] = v_q[k-1];
            st_a[k] = a_q[k-1];
            st_b[k] = bp_q[k-1];
            st_s[k] = s_q[k-1];
            st_c[k] = c_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            csum[k] = {1'b0, st_a[k][k*C +: C]} + {1'b0, st_b[k][k*C +: C]} + {{C{1'b0}}, st_c[k]};
            nx_s[k] = st_s[k];
            nx_s[k][k*C +: C] = csum[k][C-1:0];
            nx_c[k] = csum[k][C];
        end
    end

    // Final-stage flags: overflow compares the carry into the MSB with the carry out of it.
    assign raw_y          = nx_s[LAST];
    assign fin_cout       = nx_c[LAST];
    assign carry_into_msb = raw_y[WIDTH-1] ^ st_a[LAST][WIDTH-1] ^ st_b[LAST][WIDTH-1];
    assign fin_ovf        = carry_into_msb ^ fin_cout;

`ifdef ADDSUB_SAT_EN
    // Clamp toward the sign of a: positive overflow saturates to max, negative to min.
    always_comb begin
        fin_y = raw_y;
        if (fin_ovf) begin
            fin_y = st_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign fin_y = raw_y;
`endif

    // Advance every stage together; reset drops all in-flight work and clears the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            y_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]  <= st_v[k];
                c_q[k]  <= nx_c[k];
                a_q[k]  <= st_a[k];
                bp_q[k] <= st_b[k];
                s_q[k]  <= nx_s[k];
            end
            y_q    <= fin_y;
            cout_q <= fin_cout;
            ovf_q  <= fin_ovf;
            zero_q <= (fin_y == '0);
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
`timescale 1ns/1ps
module tb_pipelined_addsub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic        sub = 1'b0, cin = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_valid = 1'b0, in_ready, out_valid, cout, ovf, zero;
    logic [31:0] y;
    logic        iv1 = 1'b0, ir1, ov1, c1, o1, z1;
    logic [31:0] y1;
    logic        iv32 = 1'b0, ir32, ov32, c32, o32, z32;
    logic [31:0] y32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .cout(cout), .ovf(ovf), .zero(zero)
    );

    pipelined_addsub #(.WIDTH(32), .STAGES(1)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(ov1), .out_ready(out_ready),
        .y(y1), .cout(c1), .ovf(o1), .zero(z1)
    );

    pipelined_addsub #(.WIDTH(32), .STAGES(32)) dut_s32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(ov32), .out_ready(out_ready),
        .y(y32), .cout(c32), .ovf(o32), .zero(z32)
    );

    // Reference: {ovf, cout, y}. Borrow-free subtraction means a >= b + borrow_in.
    function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic ms, input logic mc);
        logic [32:0] r;
        logic [31:0] yy;
        logic        co;
        logic        ov;
        if (!ms) begin
            r  = {1'b0, ma} + {1'b0, mb} + 33'(mc);
            yy = r[31:0];
            co = r[32];
            ov = (ma[31] == mb[31]) && (yy[31] != ma[31]);
        end else begin
            yy = ma - mb - 32'(mc);
            co = ({1'b0, ma} >= ({1'b0, mb} + 33'(mc)));
            ov = (ma[31] != mb[31]) && (yy[31] != ma[31]);
        end
`ifdef ADDSUB_SAT_EN
        if (ov) yy = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {ov, co, yy};
    endfunction

    // Issue one operation to an idle instance (0: 4 stages, 1: 1 stage, 2: 32 stages) and wait for it.
    // lat counts cycles starting from the cycle in which the operands were presented.
    task automatic run_op(input int which, input logic [31:0] ta, input logic [31:0] tb,
                          input logic ts, input logic tc,
                          output logic [31:0] ry, output logic rc, output logic ro,
                          output logic rz, output int lat);
        logic seen;
        a = ta; b = tb; sub = ts; cin = tc;
        case (which)
            0:       in_valid = 1'b1;
            1:       iv1 = 1'b1;
            default: iv32 = 1'b1;
        endcase
        @(posedge clk); #1;
        in_valid = 1'b0; iv1 = 1'b0; iv32 = 1'b0;
        lat = 1;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            case (which)
                0:       seen = out_valid;
                1:       seen = ov1;
                default: seen = ov32;
            endcase
            if (!seen) begin
                @(posedge clk); #1;
                lat++;
            end
        end
        case (which)
            0:       begin ry = y;   rc = cout; ro = ovf; rz = zero; end
            1:       begin ry = y1;  rc = c1;   ro = o1;  rz = z1;   end
            default: begin ry = y32; rc = c32;  ro = o32; rz = z32;  end
        endcase
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (y !== 32'h0) begin errors++; $display("FAIL reset_y: got %h want 00000000", y); end
        checks++; if ({cout, ovf, zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {cout, ovf, zero}); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add_wrap();
        logic [31:0] ry; logic rc, ro, rz; int lat;
        run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, ry, rc, ro, rz, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL wrap_latency: got %0d want 4", lat); end
        checks++; if (ry !== 32'h0) begin errors++; $display("FAIL wrap_y: got %h want 00000000", ry); end
        checks++; if ({rc, ro, rz} !== 3'b101) begin errors++; $display("FAIL wrap_flags(cout,ovf,zero): got %b want 101", {rc, ro, rz}); end
    endtask

    task automatic test_add_ovf();
        logic [31:0] ry; logic rc, ro, rz; int lat;
        logic [31:0] want;
`ifdef ADDSUB_SAT_EN
        want = 32'h7FFF_FFFF;
`else
        want = 32'h8000_0000;
`endif
        run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, ry, rc, ro, rz, lat);
        checks++; if (ry !== want) begin errors++; $display("FAIL ovf_y: got %h want %h", ry, want); end
        checks++; if ({rc, ro, rz} !== 3'b010) begin errors++; $display("FAIL ovf_flags(cout,ovf,zero): got %b want 010", {rc, ro, rz}); end
    endtask

    task automatic test_sub();
        logic [31:0] ry; logic rc, ro, rz; int lat;
        run_op(0, 32'd5, 32'd7, 1'b1, 1'b0, ry, rc, ro, rz, lat);
        checks++; if (ry !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_5_7_y: got %h want fffffffe", ry); end
        checks++; if ({rc, ro, rz} !== 3'b000) begin errors++; $display("FAIL sub_5_7_flags: got %b want 000", {rc, ro, rz}); end
        run_op(0, 32'd7, 32'd5, 1'b1, 1'b1, ry, rc, ro, rz, lat);
        checks++; if (ry !== 32'h0000_0001) begin errors++; $display("FAIL sub_7_5_borrow_y: got %h want 00000001", ry); end
        checks++; if (rc !== 1'b1) begin errors++; $display("FAIL sub_7_5_borrow_cout: got %b want 1", rc); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic        vs [8];
        logic        vc [8];
        logic [31:0] ve [8];
        logic [31:0] held;
        int          got;
        int          stall_left;
        bit          stalling;
        va = '{32'd1, 32'd10, 32'h100, 32'd0, 32'h1234_5678, 32'h8000_0001, 32'hAAAA_0000, 32'd100};
        vb = '{32'd2, 32'd3, 32'hFF, 32'd1, 32'h1111_1111, 32'd1, 32'h5555_FFFF, 32'd50};
        vs = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ve = '{32'd3, 32'd7, 32'h200, 32'hFFFF_FFFF, 32'h2345_6789, 32'h8000_0000, 32'hFFFF_FFFF, 32'd49};
        got = 0; stall_left = 3; stalling = 1'b0; held = '0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    int n;
                    a = va[i]; b = vb[i]; sub = vs[i]; cin = vc[i]; in_valid = 1'b1;
                    n = 0;
                    @(negedge clk);
                    while (!in_ready && n < 20) begin @(negedge clk); n++; end
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
                    @(posedge clk); #1;
                    if (got == 3 && stall_left == 3 && !stalling) begin
                        stalling = 1'b1; out_ready = 1'b0;
                    end else if (stalling && stall_left == 0) begin
                        stalling = 1'b0; out_ready = 1'b1;
                    end
                    @(negedge clk);
                    if (stalling && stall_left > 0) begin
                        if (stall_left == 3) held = y;
                        else begin
                            checks++; if (y !== held) begin errors++; $display("FAIL stall_y_hold: got %h want %h", y, held); end
                        end
                        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
                        stall_left--;
                    end
                    if (out_valid && out_ready) begin
                        checks++; if (y !== ve[got]) begin errors++; $display("FAIL b2b_result_%0d: got %h want %h", got, y, ve[got]); end
                        got++;
                    end
                end
            end
        join
        out_ready = 1'b1;
        checks++; if (got != 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", got); end
        repeat (6) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_duplicate: got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_reset_flush();
        logic [31:0] ry; logic rc, ro, rz; int lat;
        bit stale;
        for (int i = 0; i < 3; i++) begin
            a = 32'(i + 1); b = 32'd100; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        stale = 1'b0;
        repeat (8) begin @(negedge clk); if (out_valid) stale = 1'b1; end
        checks++; if (stale) begin errors++; $display("FAIL flush_stale_result: got stale output want none"); end
        @(posedge clk); #1;
        run_op(0, 32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0, ry, rc, ro, rz, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL flush_next_latency: got %0d want 4", lat); end
        checks++; if (ry !== 32'h0000_1234) begin errors++; $display("FAIL flush_next_y: got %h want 00001234", ry); end
    endtask

    task automatic test_chain64();
        logic [31:0] lo, hi; logic rc, ro, rz, lc; int lat;
        logic [63:0] ref64;
        ref64 = 64'hFFFF_FFFF_8000_0000 + 64'h0000_0001_8000_0000;
        run_op(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, lo, lc, ro, rz, lat);
        run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lc, hi, rc, ro, rz, lat);
        checks++; if ({hi, lo} !== ref64) begin errors++; $display("FAIL chain64: got %h want %h", {hi, lo}, ref64); end
    endtask

    task automatic test_stage_variants();
        logic [31:0] ry; logic rc, ro, rz; int lat;
        logic [33:0] exp;
        logic [31:0] ta, tb; logic ts, tc;
        for (int w = 1; w <= 2; w++) begin
            for (int i = 0; i < 3; i++) begin
                ta = $urandom; tb = $urandom;
                ts = 1'($urandom_range(0, 1)); tc = 1'($urandom_range(0, 1));
                if (i == 0) begin ta = 32'h7FFF_FFF0; tb = 32'h0000_0020; ts = 1'b0; tc = 1'b1; end
                exp = model(ta, tb, ts, tc);
                run_op(w, ta, tb, ts, tc, ry, rc, ro, rz, lat);
                checks++; if (lat != (w == 1 ? 1 : 32)) begin errors++; $display("FAIL variant%0d_latency: got %0d want %0d", w, lat, (w == 1 ? 1 : 32)); end
                checks++; if ({ro, rc, ry} !== exp) begin errors++; $display("FAIL variant%0d_result_%0d: got ovf=%b cout=%b y=%h want ovf=%b cout=%b y=%h", w, i, ro, rc, ry, exp[33], exp[32], exp[31:0]); end
                checks++; if (rz !== (exp[31:0] == 32'h0)) begin errors++; $display("FAIL variant%0d_zero_%0d: got %b want %b", w, i, rz, (exp[31:0] == 32'h0)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_add_ovf();
        test_sub();
        test_back_to_back();
        test_reset_flush();
        test_chain64();
        test_stage_variants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
